// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target and bus front end.
// Holds the state encoding, the ACK/NACK bus levels and the default address.
package i2c_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRx,
        StRxAck,
        StTx,
        StTxAck,
        StWait
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA pad conditioning: 2-FF synchronisers, one history FF per line, and
// registered edge/START/STOP strobes aligned with the scl_s/sda_s levels.
module i2c_bus_sync (
    input  logic clk,
    input  logic rs,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;
    logic       scl_rise_q;
    logic       scl_fall_q;
    logic       start_q;
    logic       stop_q;

    // Sync stages reset to the idle (released) bus level so reset never makes an edge.
    always_ff @(posedge clk) begin
        if (!rs) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
            scl_rise_q <= scl_sync_q[1] & ~scl_hist_q;
            scl_fall_q <= ~scl_sync_q[1] & scl_hist_q;
            start_q    <= scl_sync_q[1] & scl_hist_q & ~sda_sync_q[1] & sda_hist_q;
            stop_q     <= scl_sync_q[1] & scl_hist_q & sda_sync_q[1] & ~sda_hist_q;
        end
    end

    // The history FFs hold the levels that match the registered strobes.
    assign scl_s     = scl_hist_q;
    assign sda_s     = sda_hist_q;
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave.sv
// Clock-oversampled I2C target: address match, byte receive with ACK, and byte
// transmit with a tx_req/wr_master handshake to the local register logic.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       scl,
    input  logic       sda,
    output logic       c_sda,
    output logic [7:0] rd_master,
    output logic       rx_valid,
    input  logic [7:0] wr_master,
    output logic       tx_req,
    output logic       busy
);

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .rs        (rs),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       rw_q, rw_d;
    logic       match_q, match_d;
    logic       c_sda_q, c_sda_d;
    logic       busy_q, busy_d;
    logic [7:0] rd_master_q, rd_master_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;

    logic [7:0] shift_in;
    logic       last_bit;
    logic       bit_fall;

    always_ff @(posedge clk) begin
        if (!rs) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            match_q     <= 1'b0;
            c_sda_q     <= I2C_NACK;
            busy_q      <= 1'b0;
            rd_master_q <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            match_q     <= match_d;
            c_sda_q     <= c_sda_d;
            busy_q      <= busy_d;
            rd_master_q <= rd_master_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
        end
    end

    // byte_done marks that 8 bits were clocked, so the following fall ends the byte.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        match_d     = match_q;
        c_sda_d     = c_sda_q;
        busy_d      = busy_q;
        rd_master_d = rd_master_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        shift_in    = {shift_q[6:0], sda_s};
        last_bit    = (bit_cnt_q == 3'd7);
        bit_fall    = scl_fall & ~scl_s;

        if (stop_det) begin
            state_d     = StIdle;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            c_sda_d     = I2C_NACK;
            busy_d      = 1'b0;
        end else if (start_det) begin
            state_d     = StAddr;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            c_sda_d     = I2C_NACK;
        end else begin
            unique case (state_q)
                StIdle, StWait: begin
                    c_sda_d = I2C_NACK;
                end
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            byte_done_d = 1'b1;
                            rw_d        = sda_s;
                            match_d     = (shift_q[6:0] == SLAVE_ADDR);
                            tx_req_d    = (shift_q[6:0] == SLAVE_ADDR) && sda_s;
                        end
                    end else if (bit_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (match_q) begin
                            state_d = StAddrAck;
                            c_sda_d = I2C_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StWait;
                            c_sda_d = I2C_NACK;
                            busy_d  = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (bit_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d = StTx;
                            shift_d = wr_master;
                            c_sda_d = wr_master[7];
                        end else begin
                            state_d = StRx;
                            c_sda_d = I2C_NACK;
                        end
                    end
                end
                StRx: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            byte_done_d = 1'b1;
                            rd_master_d = shift_in;
                            rx_valid_d  = 1'b1;
                        end
                    end else if (bit_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        state_d     = StRxAck;
                        c_sda_d     = I2C_ACK;
                    end
                end
                StRxAck: begin
                    if (bit_fall) begin
                        state_d   = StRx;
                        bit_cnt_d = 3'd0;
                        c_sda_d   = I2C_NACK;
                    end
                end
                StTx: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (bit_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            state_d     = StTxAck;
                            c_sda_d     = I2C_NACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            c_sda_d = shift_q[6];
                        end
                    end
                end
                StTxAck: begin
                    // A fall here can only follow an ACKed rise; a NACK already left for StWait.
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = StWait;
                        end
                    end else if (bit_fall) begin
                        state_d   = StTx;
                        bit_cnt_d = 3'd0;
                        shift_d   = wr_master;
                        c_sda_d   = wr_master[7];
                    end
                end
                default: begin
                    state_d = StIdle;
                    c_sda_d = I2C_NACK;
                end
            endcase
        end
    end

    assign c_sda     = c_sda_q;
    assign rd_master = rd_master_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus-level I2C master model drives directed and random
// transactions; expectations come from the address/direction rules of the protocol.
module tb_i2c_slave;

    localparam int H = 24;
    localparam logic [6:0] ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rs;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       c_sda;
    logic [7:0] rd_master;
    logic       rx_valid;
    logic [7:0] wr_master;
    logic       tx_req;
    logic       busy;

    assign sda_bus = sda_m & c_sda;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk       (clk),
        .rs        (rs),
        .scl       (scl_m),
        .sda       (sda_bus),
        .c_sda     (c_sda),
        .rd_master (rd_master),
        .rx_valid  (rx_valid),
        .wr_master (wr_master),
        .tx_req    (tx_req),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int low_cnt = 0;
    logic [7:0] rx_got[$];
    logic [7:0] tx_src[$];
    logic [7:0] payload[4];
    logic [7:0] exp_rd = 8'h00;

    // Bus-side monitors and the local-logic responder for tx_req.
    initial forever begin
        @(negedge clk);
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            rx_got.push_back(rd_master);
        end
        if (tx_req === 1'b1) begin
            tx_cnt++;
            if (tx_src.size() > 0) wr_master = tx_src.pop_front();
            else wr_master = 8'hFF;
        end
        if (c_sda === 1'b0) low_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cond();
        repeat (5) @(negedge clk);
        sda_m = 1'b1;
        repeat (H) @(negedge clk);
        scl_m = 1'b1;
        repeat (H) @(negedge clk);
        sda_m = 1'b0;
        repeat (H) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        repeat (5) @(negedge clk);
        sda_m = 1'b0;
        repeat (H) @(negedge clk);
        scl_m = 1'b1;
        repeat (H) @(negedge clk);
        sda_m = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        repeat (5) @(negedge clk);
        sda_m = b;
        repeat (H - 5) @(negedge clk);
        scl_m = 1'b1;
        repeat (H) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        repeat (5) @(negedge clk);
        sda_m = 1'b1;
        repeat (H - 5) @(negedge clk);
        scl_m = 1'b1;
        repeat (H / 2) @(negedge clk);
        b = sda_bus;
        repeat (H / 2) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        send_bit(nack);
    endtask

    // Whole transaction: START, address byte, n data bytes, STOP, then counts.
    task automatic xfer(input logic [7:0] ab, input int n, input string tag);
        logic       hit;
        logic       rd;
        logic       ack;
        logic [7:0] got;
        int         rx0;
        int         tx0;
        hit = (ab[7:1] == ADDR);
        rd  = ab[0] && hit;
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        rx_got.delete();
        tx_src.delete();
        if (rd) for (int i = 0; i < n; i++) tx_src.push_back(payload[i]);
        start_cond();
        write_byte(ab, ack);
        check({tag, " addr ack"}, 32'(ack), hit ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            if (rd) begin
                read_byte(got, (i == n - 1));
                check({tag, " read data"}, 32'(got), 32'(payload[i]));
            end else begin
                write_byte(payload[i], ack);
                check({tag, " data ack"}, 32'(ack), hit ? 32'd0 : 32'd1);
            end
        end
        check({tag, " busy before stop"}, 32'(busy), 32'(hit));
        stop_cond();
        check({tag, " busy after stop"}, 32'(busy), 32'd0);
        check({tag, " c_sda after stop"}, 32'(c_sda), 32'd1);
        check({tag, " rx_valid count"}, 32'(rx_cnt - rx0), (hit && !rd) ? 32'(n) : 32'd0);
        check({tag, " tx_req count"}, 32'(tx_cnt - tx0), rd ? 32'(n) : 32'd0);
        if (hit && !rd) begin
            for (int i = 0; i < n; i++) begin
                if (i < rx_got.size()) check({tag, " rx byte"}, 32'(rx_got[i]), 32'(payload[i]));
                else check({tag, " rx byte missing"}, 32'(rx_got.size()), 32'(n));
            end
            exp_rd = payload[n - 1];
        end
        check({tag, " rd_master held"}, 32'(rd_master), 32'(exp_rd));
    endtask

    initial begin
        logic       ack;
        logic [7:0] got;
        int         rx0;
        int         tx0;
        int         low0;
        logic [6:0] a;
        logic       rw;
        int         n;

        rs        = 1'b0;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        wr_master = 8'h00;
        repeat (4) @(negedge clk);
        check("reset c_sda", 32'(c_sda), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rd_master", 32'(rd_master), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset tx_req", 32'(tx_req), 32'd0);
        rs = 1'b1;
        repeat (10) @(negedge clk);

        payload[0] = 8'h3C;
        xfer(8'hA0, 1, "write 3C");

        payload[0] = 8'h55;
        low0 = low_cnt;
        xfer(8'hA2, 1, "mismatch");
        check("mismatch c_sda never low", 32'(low_cnt - low0), 32'd0);

        payload[0] = 8'hA5;
        payload[1] = 8'h0F;
        xfer(8'hA1, 2, "read A5 0F");

        for (int t = 0; t < 6; t++) begin
            a = ($urandom_range(0, 1) == 0) ? ADDR : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
            xfer({a, rw}, n, "random");
        end

        // Repeated START four bits into a write byte, then a read.
        rx0 = rx_cnt;
        start_cond();
        write_byte(8'hA0, ack);
        check("rstart first ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        tx0 = tx_cnt;
        tx_src.delete();
        payload[0] = 8'($urandom);
        tx_src.push_back(payload[0]);
        start_cond();
        write_byte(8'hA1, ack);
        check("rstart read ack", 32'(ack), 32'd0);
        check("rstart tx_req", 32'(tx_cnt - tx0), 32'd1);
        read_byte(got, 1'b1);
        check("rstart read data", 32'(got), 32'(payload[0]));
        stop_cond();
        check("rstart no rx_valid", 32'(rx_cnt - rx0), 32'd0);

        // STOP after five data bits discards the partial byte.
        rx0 = rx_cnt;
        start_cond();
        write_byte(8'hA0, ack);
        check("stop-mid addr ack", 32'(ack), 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        stop_cond();
        check("stop-mid no rx_valid", 32'(rx_cnt - rx0), 32'd0);
        check("stop-mid rd_master", 32'(rd_master), 32'(exp_rd));
        check("stop-mid c_sda", 32'(c_sda), 32'd1);
        check("stop-mid busy", 32'(busy), 32'd0);

        // Reset while the target is driving the address ACK.
        payload[0] = 8'h96;
        xfer(8'hA0, 1, "pre-reset write");
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
        sda_m = 1'b1;
        repeat (10) @(negedge clk);
        check("ack driven before reset", 32'(c_sda), 32'd0);
        check("busy before reset", 32'(busy), 32'd1);
        rs = 1'b0;
        @(negedge clk);
        rs = 1'b1;
        check("reset mid c_sda", 32'(c_sda), 32'd1);
        check("reset mid busy", 32'(busy), 32'd0);
        check("reset mid rd_master", 32'(rd_master), 32'd0);
        exp_rd = 8'h00;
        repeat (H) @(negedge clk);
        scl_m = 1'b1;
        repeat (H) @(negedge clk);
        scl_m = 1'b0;
        payload[0] = 8'h5A;
        xfer(8'hA0, 1, "post-reset write");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
